core_wb_arbiter: RTL
====================

Name: core_wb_arbiter

Overview:
- Shares the single register-file write port among all execution units (branch, ALU, multiplier, memory) that each present a `wb_line` and obey a per-unit `wb_stall`.
- Each cycle it picks one ready unit by rotating priority and registers that line toward the register file. It stalls the other ready units and reports a RAW mask of in-flight destination registers to issue.

Parameters:
- UNITS, 4, number of requesting execution units (2..8); unit index 0 is the branch unit.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- unit_wb  in  UNITS x $bits(wb_line)  per-unit writeback line {ready, rd, value}, index i = unit i
- rf_stall  in  1  register-file port unavailable this cycle
- unit_stall  out  UNITS  per-unit wb_stall; unit must hold its wb line while high
- rf_wb  out  $bits(wb_line)  registered write to register file
- raw_mask  out  hword  one bit per architectural register with a writeback still pending in this block or its inputs

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - rf_wb.ready=0, rf_wb.rd=0, rf_wb.value=0.
  - Priority pointer ptr=0.
  - unit_stall and raw_mask follow the combinational rules below with rf_wb.ready=0.
- Request set R[i] = unit_wb[i].ready.
- Grant g: the first i with R[i]=1, scanning ptr, ptr+1, ..., wrapping at UNITS-1 to 0. No grant if R=0.
- unit_stall[i] (combinational, same cycle):
  - rf_stall=1: R[i].
  - rf_stall=0: R[i] && i!=g.
  - A non-ready unit never sees a stall.
- Posedge, rf_stall=0:
  - Grant exists: rf_wb <= unit_wb[g] with ready=1, and ptr <= (g+1) mod UNITS.
  - R=0: rf_wb.ready <= 0; rd and value don't-care; ptr holds.
- Posedge, rf_stall=1: rf_wb and ptr hold.
- Latency: one cycle from a granted unit_wb to rf_wb.ready.
- Throughput: one writeback per cycle while rf_stall=0.
- Fairness: a unit that stays ready is granted within UNITS cycles of rf_stall=0.
- raw_mask (combinational) is the OR of:
  - bit rd of every unit_wb with ready=1;
  - bit rf_wb.rd if rf_wb.ready=1.
- Boundary conditions:
  - Two units ready with the same rd: both are arbitrated normally. Ordering between them is the issue stage's responsibility via raw_mask. The arbiter does not merge or drop either line.
  - UNITS not a power of two: ptr wraps explicitly from UNITS-1 to 0; ptr values >= UNITS are unreachable.
  - A unit deasserting ready while stalled is illegal; the bench asserts this.
  - rd=0 is passed through unchanged; register-file policy decides.
  - rst asserted mid-transfer: the pending rf_wb is dropped (ready=0 next cycle) and ptr returns to 0. Units are reset by the same rst.

Decomposition:
- Shared package `core/uarch.sv` already holds `wb_line`, `hword`, `reg_num` and `word`. Add only a `UNITS`-sized unit index typedef if needed.
- raw_mask generation instantiates `core_raw_mask` once per input plus once for rf_wb.
- One sub-module is natural: `core_rr_pick` (combinational rotating-priority picker: R, ptr -> g, valid). It keeps the arbiter body to registers and glue.

Test Plan:
- Reset, all idle: rst=1 for 2 cycles then 0, R=0000 -> rf_wb.ready=0, unit_stall=0000, raw_mask=0000.
- Single request: unit 2 ready {rd=5, value=0x1234_5678} for one cycle -> unit_stall=0000; next cycle rf_wb={1,5,0x12345678} and raw_mask bit5=1 for that cycle.
- Round-robin, all four ready and held:
  - Grant order is 0,1,2,3,0.
  - In the first cycle unit_stall=1110.
  - rf_wb.rd follows the units' rd in that order (unit 0: rd=1, unit 1: rd=2, unit 2: rd=3, unit 3: rd=4).
- rf_stall: units 0 and 3 ready (rd=7, rd=9), rf_stall=1 for 3 cycles:
  - unit_stall=1001; rf_wb and ptr frozen; raw_mask has bits 7 and 9.
  - After release, unit 0 is granted (ptr=0), then unit 3.
- Same rd collision: units 1 and 2 both ready with rd=4, values 0xA and 0xB, ptr=2 -> unit 2 written first (0xB), unit 1 next cycle (0xA); raw_mask bit4 stays set until the last write leaves rf_wb.
- Reset mid-operation: rst=1 while rf_wb.ready=1 and ptr=3 -> next cycle rf_wb.ready=0 and ptr=0; the first grant after reset goes to the lowest ready index.

Source files
------------

// File: rtl/core_wb_arbiter_pkg.sv
// Shared micro-architecture types for the writeback path: register numbers,
// data words, the per-unit writeback line and the register-bitmap half-word.
package core_wb_arbiter_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned MAX_UNITS = 8;

  typedef logic [3:0]          reg_num;
  typedef logic [31:0]         word;
  typedef logic [NUM_REGS-1:0] hword;

  // Wide enough for any legal unit count (2..8).
  typedef logic [2:0] unit_idx_t;

  typedef struct packed {
    logic   ready;
    reg_num rd;
    word    value;
  } wb_line;

endpackage

// File: rtl/core_raw_mask.sv
// Decodes one writeback line into a one-hot destination-register bitmap
// (all zeros when the line is not ready).
import core_wb_arbiter_pkg::*;

module core_raw_mask (
  input  wb_line line_i,
  output hword   mask_o
);

  always_comb begin
    mask_o = '0;
    if (line_i.ready) begin
      mask_o[line_i.rd] = 1'b1;
    end else begin
      mask_o = '0;
    end
  end

endmodule

// File: rtl/core_rr_pick.sv
// Rotating-priority picker: returns the first requester at or after ptr_i,
// wrapping explicitly at N-1 so N need not be a power of two.
import core_wb_arbiter_pkg::*;

module core_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  unit_idx_t    ptr_i,
  output unit_idx_t    grant_o,
  output logic         valid_o
);

  logic [7:0] req_ext_s;
  logic [3:0] idx_s;
  logic       found_s;

  always_comb begin
    req_ext_s = 8'(req_i);
    idx_s     = 4'd0;
    found_s   = 1'b0;
    grant_o   = 3'd0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, ptr_i} + 4'(k);
      if (idx_s >= 4'(N)) begin
        idx_s = idx_s - 4'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_ext_s[idx_s[2:0]]) begin
        found_s = 1'b1;
        grant_o = idx_s[2:0];
      end else begin
        found_s = found_s;
      end
    end
    valid_o = found_s;
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Shares the register-file write port among the execution units: one
// rotating-priority grant per cycle, registered toward the register file.
import core_wb_arbiter_pkg::*;

module core_wb_arbiter #(
  parameter int UNITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  wb_line [UNITS-1:0] unit_wb,
  input  logic               rf_stall,
  output logic   [UNITS-1:0] unit_stall,
  output wb_line             rf_wb,
  output hword               raw_mask
);

  wb_line     rf_wb_q, rf_wb_d;
  unit_idx_t  ptr_q, ptr_d;
  logic [UNITS-1:0] req_s;
  unit_idx_t  grant_s;
  logic       grant_valid_s;
  wb_line     sel_line_s;
  hword       unit_mask_s [UNITS];
  hword       rf_mask_s;

  always_comb begin
    req_s = '0;
    for (int i = 0; i < UNITS; i++) begin
      req_s[i] = unit_wb[i].ready;
    end
  end

  core_rr_pick #(.N(UNITS)) u_pick (
    .req_i   (req_s),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .valid_o (grant_valid_s)
  );

  // Explicit mux keeps the grant index within the unit range for any UNITS.
  always_comb begin
    sel_line_s = '0;
    for (int i = 0; i < UNITS; i++) begin
      if (grant_s == unit_idx_t'(i)) begin
        sel_line_s = unit_wb[i];
      end else begin
        sel_line_s = sel_line_s;
      end
    end
  end

  always_comb begin
    unit_stall = '0;
    for (int i = 0; i < UNITS; i++) begin
      unit_stall[i] = req_s[i] &
                      (rf_stall | ~(grant_valid_s & (grant_s == unit_idx_t'(i))));
    end
  end

  always_comb begin
    rf_wb_d = rf_wb_q;
    ptr_d   = ptr_q;
    if (rf_stall) begin
      rf_wb_d = rf_wb_q;
      ptr_d   = ptr_q;
    end else if (grant_valid_s) begin
      rf_wb_d       = sel_line_s;
      rf_wb_d.ready = 1'b1;
      if (grant_s == unit_idx_t'(UNITS - 1)) begin
        ptr_d = 3'd0;
      end else begin
        ptr_d = grant_s + 3'd1;
      end
    end else begin
      rf_wb_d.ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wb_q <= '0;
      ptr_q   <= 3'd0;
    end else begin
      rf_wb_q <= rf_wb_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rf_wb = rf_wb_q;

  // Pending destinations: every ready input plus the line sitting in rf_wb.
  for (genvar gi = 0; gi < UNITS; gi++) begin : g_unit_mask
    core_raw_mask u_mask (
      .line_i (unit_wb[gi]),
      .mask_o (unit_mask_s[gi])
    );
  end

  core_raw_mask u_rf_mask (
    .line_i (rf_wb_q),
    .mask_o (rf_mask_s)
  );

  always_comb begin
    raw_mask = rf_mask_s;
    for (int i = 0; i < UNITS; i++) begin
      raw_mask = raw_mask | unit_mask_s[i];
    end
  end

endmodule
